// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared encodings and baud helpers for the UART transmitter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int calc_cnt_width(input int baud_div);
        return (baud_div <= 2) ? 1 : $clog2(baud_div);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module  : uart_baud_gen
// Brief   : Bit-period counter; pulses o_bit_tick on the last clock of a bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_baud_gen #(
    parameter int BAUD_DIV = 10,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_bit_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_end;

    assign w_at_end   = (r_cnt == CNT_W'(BAUD_DIV - 1));
    assign o_bit_tick = w_at_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || w_at_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module  : uart_tx
// Brief   : Byte-wide UART transmitter, configurable parity and stop bits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_tx_en,
    input  logic [7:0] uart_tx_data,
    output logic       uart_tx_busy,
    output logic       uart_txd
);

    localparam int   BAUD_DIV  = calc_baud_div(CLK_FREQ, BAUD_RATE);
    localparam int   CNT_W     = calc_cnt_width(BAUD_DIV);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_idx;
    logic       r_stop_idx;
    logic       r_parity;
    logic       r_txd;
    logic       r_busy;

    logic       w_bit_tick;
    logic       w_clear;
    logic       w_parity;
    logic       w_frame_end;
    logic       w_accept;

    assign w_clear     = (r_state == S_IDLE);
    assign w_parity    = (PARITY == PARITY_ODD) ? ~^uart_tx_data : ^uart_tx_data;
    assign w_frame_end = (r_state == S_STOP) && w_bit_tick && (r_stop_idx == STOP_LAST);
    // A request still pending on the last stop clock chains the next frame with no idle gap.
    assign w_accept    = uart_tx_en && ((r_state == S_IDLE) || w_frame_end);

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV),
        .CNT_W    (CNT_W)
    ) u_baud_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .o_bit_tick (w_bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_parity   <= 1'b0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
        end else if (w_accept) begin
            r_state  <= S_START;
            r_shift  <= uart_tx_data;
            r_parity <= w_parity;
            r_txd    <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd  <= 1'b1;
                    r_busy <= 1'b0;
                end
                S_START: begin
                    if (w_bit_tick) begin
                        r_state   <= S_DATA;
                        r_txd     <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (w_bit_tick) begin
                        if (r_bit_idx == 3'd7) begin
                            r_stop_idx <= 1'b0;
                            if (PARITY != PARITY_NONE) begin
                                r_state <= S_PARITY;
                                r_txd   <= r_parity;
                            end else begin
                                r_state <= S_STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_txd     <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_tick) begin
                        r_state    <= S_STOP;
                        r_txd      <= 1'b1;
                        r_stop_idx <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (w_bit_tick) begin
                        if (r_stop_idx == STOP_LAST) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign uart_txd     = r_txd;
    assign uart_tx_busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module  : tb_uart_tx
// Brief   : Self-checking bench for uart_tx across four parity/stop configurations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx;

    localparam int CF  = 1000;
    localparam int BR  = 100;
    localparam int DIV = 10;
    localparam int PAR [4] = '{0, 2, 1, 0};
    localparam int STP [4] = '{1, 1, 1, 2};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] en    = '0;
    logic [7:0] data [4];
    logic [3:0] busy;
    logic [3:0] txd;

    int  checks   = 0;
    int  failures = 0;
    bit  chk_on   = 1'b0;

    int          rem   [4];
    int          pos   [4];
    logic [11:0] fbits [4];

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .uart_tx_en(en[0]), .uart_tx_data(data[0]),
        .uart_tx_busy(busy[0]), .uart_txd(txd[0]));
    uart_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .uart_tx_en(en[1]), .uart_tx_data(data[1]),
        .uart_tx_busy(busy[1]), .uart_txd(txd[1]));
    uart_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .uart_tx_en(en[2]), .uart_tx_data(data[2]),
        .uart_tx_busy(busy[2]), .uart_txd(txd[2]));
    uart_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .uart_tx_en(en[3]), .uart_tx_data(data[3]),
        .uart_tx_busy(busy[3]), .uart_txd(txd[3]));

    // Frame as a bit list: start, data LSB first, optional parity, then stop 1s.
    function automatic logic [11:0] build(input logic [7:0] b, input int par);
        logic [11:0] f;
        int          ones;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            if (b[i]) ones++;
        end
        if (par == 2) f[9] = (ones % 2 == 1);
        if (par == 1) f[9] = (ones % 2 == 0);
        return f;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d actual=%0h required=%0h t=%0t", name, d, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 4; d++) begin
            if (!rst_n) begin
                rem[d] = 0;
            end else begin
                if (rem[d] > 0) begin
                    pos[d]++;
                    rem[d]--;
                end
                if (rem[d] == 0 && en[d]) begin
                    fbits[d] = build(data[d], PAR[d]);
                    pos[d]   = 0;
                    rem[d]   = (9 + (PAR[d] != 0 ? 1 : 0) + STP[d]) * DIV;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 4; d++) begin
                chk("busy_model", d, 32'(busy[d]), 32'(rem[d] > 0));
                chk("txd_model", d, 32'(txd[d]),
                    32'((rem[d] > 0) ? fbits[d][pos[d] / DIV] : 1'b1));
            end
        end
    end

    task automatic pulse(input int d, input logic [7:0] b);
        @(negedge clk);
        en[d]   = 1'b1;
        data[d] = b;
        @(negedge clk);
        en[d]   = 1'b0;
        data[d] = 8'($urandom);
    endtask

    task automatic measure(input int d, input int inj, input logic [7:0] ib,
                           output logic [11:0] samp, output int blen);
        int n;
        n    = 0;
        samp = '1;
        while (busy[d] && n < 400) begin
            if (n % DIV == DIV / 2 && n / DIV < 12) samp[n / DIV] = txd[d];
            if (n == inj) begin
                en[d]   = 1'b1;
                data[d] = ib;
            end else if (inj >= 0 && n == inj + 1) begin
                en[d] = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        blen = n;
    endtask

    logic [11:0] s;
    int          bl;
    int          gap;
    logic        b_first, b_start2, b_bit2;

    initial begin
        for (int d = 0; d < 4; d++) data[d] = '0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        repeat (50) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk("idle_txd", d, 32'(txd[d]), 32'd1);
            chk("idle_busy", d, 32'(busy[d]), 32'd0);
        end

        pulse(0, 8'h55);
        measure(0, -1, 8'h00, s, bl);
        chk("8n1_55_line", 0, 32'(s[9:0]), 32'b1010101010);
        chk("8n1_55_busy_len", 0, bl, 100);

        pulse(1, 8'h41);
        measure(1, -1, 8'h00, s, bl);
        chk("even_41_line", 1, 32'(s[10:0]), 32'b10010000010);
        chk("even_41_busy_len", 1, bl, 110);

        pulse(2, 8'h41);
        measure(2, -1, 8'h00, s, bl);
        chk("odd_41_line", 2, 32'(s[10:0]), 32'b11010000010);
        chk("odd_41_busy_len", 2, bl, 110);

        pulse(3, 8'hFF);
        measure(3, -1, 8'h00, s, bl);
        chk("stop2_ff_line", 3, 32'(s[10:0]), 32'b11111111110);
        chk("stop2_ff_busy_len", 3, bl, 110);

        pulse(0, 8'hC3);
        measure(0, 30, 8'h00, s, bl);
        chk("ignore_line", 0, 32'(s[9:0]), 32'b1110000110);
        chk("ignore_busy_len", 0, bl, 100);
        repeat (5) @(negedge clk);
        chk("ignore_no_queue", 0, 32'(busy[0]), 32'd0);

        @(negedge clk);
        en[0]   = 1'b1;
        data[0] = 8'hA5;
        @(negedge clk);
        data[0] = 8'h3C;
        gap = 0;
        b_first = 1'b0; b_start2 = 1'b1; b_bit2 = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (!busy[0]) gap++;
            if (n == 15)  b_first  = txd[0];
            if (n == 105) b_start2 = txd[0];
            if (n == 135) b_bit2   = txd[0];
            if (n == 150) en[0] = 1'b0;
            @(negedge clk);
        end
        chk("b2b_busy_gap", 0, gap, 0);
        chk("b2b_first_bit0", 0, 32'(b_first), 32'd1);
        chk("b2b_second_start", 0, 32'(b_start2), 32'd0);
        chk("b2b_second_bit2", 0, 32'(b_bit2), 32'd1);
        chk("b2b_end_idle", 0, 32'(busy[0]), 32'd0);

        pulse(0, 8'h00);
        repeat (45) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            chk("async_rst_txd", d, 32'(txd[d]), 32'd1);
            chk("async_rst_busy", d, 32'(busy[d]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        pulse(0, 8'h81);
        measure(0, -1, 8'h00, s, bl);
        chk("post_rst_line", 0, 32'(s[9:0]), 32'b1100000010);
        chk("post_rst_busy_len", 0, bl, 100);

        repeat (60) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                en[d]   = 1'($urandom_range(0, 1));
                data[d] = 8'($urandom);
            end
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                for (int d = 0; d < 4; d++) data[d] = 8'($urandom);
            end
            en = '0;
            repeat ($urandom_range(0, 120)) @(negedge clk);
        end
        repeat (130) @(negedge clk);
        for (int d = 0; d < 4; d++) chk("final_idle", d, 32'(busy[d]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-wide UART transmitter. Directly downstream of the table/matrix printers: it consumes their `uart_tx_en`/`uart_tx_data` and returns `uart_tx_busy`.
- Serialises one 8N1 frame by default, with parity and stop bits configurable.
- Drives the board TXD pin, idle-high.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in baud. Bit period BAUD_DIV = CLK_FREQ / BAUD_RATE, integer truncated; BAUD_DIV must be ≥ 2.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- uart_tx_en  input  1  send request, level-sensitive, sampled only when idle.
- uart_tx_data  input  8  byte to send, sampled in the same cycle the request is accepted.
- uart_tx_busy  output  1  high from the cycle after acceptance until the frame ends.
- uart_txd  output  1  serial line, idle 1.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: `uart_txd` = 1, `uart_tx_busy` = 0, state = S_IDLE, baud counter = 0, bit index = 0, shift register = 0.
- State machine: S_IDLE → S_START → S_DATA → [S_PARITY] → S_STOP → S_IDLE.
- Acceptance: at a rising edge in S_IDLE with `uart_tx_en` = 1:
  - latch `uart_tx_data` into the shift register;
  - compute the parity bit (odd: ~^data; even: ^data);
  - go to S_START, driving `uart_tx_busy` = 1 and `uart_txd` = 0 from that edge.
  - Latency from the request edge to the start bit is 0 extra cycles (outputs are registered).
- Bit timing:
  - Each bit holds for exactly BAUD_DIV clocks.
  - The baud counter runs 0..BAUD_DIV-1; the state or bit advances when the counter reaches BAUD_DIV-1, and the counter then wraps to 0.
- S_DATA: sends 8 bits LSB first. The bit index runs 0..7; after bit 7 the FSM goes to S_PARITY if PARITY ≠ 0, otherwise to S_STOP.
- S_PARITY: drives the parity bit for one bit period.
- S_STOP: `uart_txd` = 1 for STOP_BITS × BAUD_DIV clocks. On the final cycle it returns to S_IDLE and `uart_tx_busy` falls at that same edge.
- Frame length: busy stays high for exactly (1 + 8 + P + STOP_BITS) × BAUD_DIV clocks, where P = (PARITY ≠ 0).
- Request while busy: `uart_tx_en` is ignored and nothing is queued; the data input may change freely.
- Request still high after a frame ends: a new frame starts at the first S_IDLE edge. This gives back-to-back frames with 0 idle clocks.
- Upstream contract: callers drop `uart_tx_en` upon seeing busy = 1. A one-cycle pulse is sufficient.
- Reset mid-frame: the FSM returns immediately to S_IDLE, `uart_txd` = 1 and busy = 0. No partial-frame completion.
- Glitch-free output: `uart_txd` is driven only from a flop.

Decomposition:
- Package `uart_pkg` holds:
  - parity encodings PARITY_NONE = 0, PARITY_ODD = 1, PARITY_EVEN = 2;
  - state localparams S_IDLE..S_STOP as 3-bit codes;
  - a constant function computing BAUD_DIV and the counter width (clog2).
- Sub-module `uart_baud_gen` is a natural split: a counter with a synchronous clear on frame start, emitting a 1-cycle `bit_tick` when the count equals BAUD_DIV-1. `uart_tx` holds the FSM and shift register.

Test Plan:
All cases use CLK_FREQ = 1000 and BAUD_RATE = 100, so BAUD_DIV = 10.
- Reset, then hold idle for 50 clocks → `uart_txd` = 1 and busy = 0 throughout.
- 8N1, 0x55, 1-cycle `uart_tx_en` pulse:
  - busy rises at the request edge and stays high exactly 100 clocks;
  - line samples at bit centres read 0,1,0,1,0,1,0,1,0,1.
- Even parity, 0x41 → 11-bit frame with parity bit 0, busy for 110 clocks. With PARITY = 1, the same byte gives parity bit 1.
- STOP_BITS = 2, 0xFF → start 0, eight 1s, stop held 20 clocks, busy for 110 clocks.
- Second pulse 30 clocks into a frame with data 0x00 → ignored; the line carries only the first byte.
- `uart_tx_en` held high continuously with 0xA5 then 0x3C → two frames back-to-back, busy low for 0 clocks between them.
- `rst_n` asserted at clock 45 of a frame → `uart_txd` = 1 and busy = 0 asynchronously. After release, the next request starts a clean start bit.
